// File: rtl/axi_lite_a32_d32_master_ll_tx.sv
// Credit-based link transmitter for the AR, AW and W channels of an AXI-Lite master.
// Optional macro AXI_LITE_LL_TX_CREDIT_ERR_EN enables the sticky credit_err flags.

module axi_lite_ll_tx_chan #(
  parameter int DATA_W      = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int INIT_CREDIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              online,
  input  logic              vld,
  input  logic [DATA_W-1:0] din,
  output logic              ready,
  input  logic              rx_credit,
  output logic              push,
  output logic [DATA_W-1:0] dout,
  output logic              err
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [3:0] INIT_C = 4'(INIT_CREDIT);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [AW:0]       occ;
  logic [3:0]        credit;
  logic              started;
  logic              wr;
  logic              pop;

  // Ready comes from registered state only; held low until the first edge out of reset.
  assign ready = started && (occ < DEPTH_C);
  assign wr    = vld && ready;
  assign pop   = (occ != '0) && (credit != 4'd0) && online;

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started <= 1'b0;
      wptr    <= '0;
      rptr    <= '0;
      occ     <= '0;
    end else begin
      started <= 1'b1;
      if (wr)  wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      case ({wr, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Returned credits saturate at the initial far-end buffer size.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit <= INIT_C;
    end else begin
      case ({pop, rx_credit})
        2'b10:   credit <= credit - 4'd1;
        2'b01:   credit <= (credit == INIT_C) ? credit : credit + 4'd1;
        default: credit <= credit;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push <= 1'b0;
      dout <= '0;
    end else begin
      push <= pop;
      if (pop) dout <= mem[rptr];
    end
  end

`ifdef AXI_LITE_LL_TX_CREDIT_ERR_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (rx_credit && !pop && (credit == INIT_C)) begin
      err_q <= 1'b1;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

module axi_lite_a32_d32_master_ll_tx #(
  parameter int FIFO_DEPTH  = 4,
  parameter int INIT_CREDIT = 8
) (
  input  logic        clk_wr,
  input  logic        rst_wr_n,
  input  logic        tx_online,
  input  logic        user_ar_lite_vld,
  input  logic        user_aw_lite_vld,
  input  logic        user_w_lite_vld,
  input  logic [31:0] txfifo_ar_lite_data,
  input  logic [31:0] txfifo_aw_lite_data,
  input  logic [35:0] txfifo_w_lite_data,
  output logic        user_ar_lite_ready,
  output logic        user_aw_lite_ready,
  output logic        user_w_lite_ready,
  output logic        tx_ar_push,
  output logic        tx_aw_push,
  output logic        tx_w_push,
  output logic [31:0] tx_ar_data,
  output logic [31:0] tx_aw_data,
  output logic [35:0] tx_w_data,
  input  logic        rx_ar_credit,
  input  logic        rx_aw_credit,
  input  logic        rx_w_credit,
  output logic [2:0]  credit_err
);
  logic err_ar;
  logic err_aw;
  logic err_w;

  axi_lite_ll_tx_chan #(.DATA_W(32), .FIFO_DEPTH(FIFO_DEPTH), .INIT_CREDIT(INIT_CREDIT)) u_ar (
    .clk(clk_wr), .rst_n(rst_wr_n), .online(tx_online),
    .vld(user_ar_lite_vld), .din(txfifo_ar_lite_data), .ready(user_ar_lite_ready),
    .rx_credit(rx_ar_credit), .push(tx_ar_push), .dout(tx_ar_data), .err(err_ar)
  );

  axi_lite_ll_tx_chan #(.DATA_W(32), .FIFO_DEPTH(FIFO_DEPTH), .INIT_CREDIT(INIT_CREDIT)) u_aw (
    .clk(clk_wr), .rst_n(rst_wr_n), .online(tx_online),
    .vld(user_aw_lite_vld), .din(txfifo_aw_lite_data), .ready(user_aw_lite_ready),
    .rx_credit(rx_aw_credit), .push(tx_aw_push), .dout(tx_aw_data), .err(err_aw)
  );

  axi_lite_ll_tx_chan #(.DATA_W(36), .FIFO_DEPTH(FIFO_DEPTH), .INIT_CREDIT(INIT_CREDIT)) u_w (
    .clk(clk_wr), .rst_n(rst_wr_n), .online(tx_online),
    .vld(user_w_lite_vld), .din(txfifo_w_lite_data), .ready(user_w_lite_ready),
    .rx_credit(rx_w_credit), .push(tx_w_push), .dout(tx_w_data), .err(err_w)
  );

  assign credit_err = {err_w, err_aw, err_ar};

endmodule

// File: tb/tb_axi_lite_a32_d32_master_ll_tx.sv
// Randomized bench for axi_lite_a32_d32_master_ll_tx with a queue/credit reference model
// and directed scenarios pinned by hand-computed values.

module tb_axi_lite_a32_d32_master_ll_tx;
  localparam int D    = 4;
  localparam int INIT = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        online;
  logic [2:0]  vld;
  logic [35:0] din [3];
  logic [2:0]  rx;

  logic        user_ar_lite_ready, user_aw_lite_ready, user_w_lite_ready;
  logic        tx_ar_push, tx_aw_push, tx_w_push;
  logic [31:0] tx_ar_data, tx_aw_data;
  logic [35:0] tx_w_data;
  logic [2:0]  credit_err;

  logic [2:0]  rdy_o;
  logic [2:0]  push_o;
  logic [35:0] dat_o [3];

  assign rdy_o  = {user_w_lite_ready, user_aw_lite_ready, user_ar_lite_ready};
  assign push_o = {tx_w_push, tx_aw_push, tx_ar_push};
  assign dat_o[0] = {4'b0, tx_ar_data};
  assign dat_o[1] = {4'b0, tx_aw_data};
  assign dat_o[2] = tx_w_data;

  always #5 clk = ~clk;

  axi_lite_a32_d32_master_ll_tx #(.FIFO_DEPTH(D), .INIT_CREDIT(INIT)) dut (
    .clk_wr(clk), .rst_wr_n(rst_n), .tx_online(online),
    .user_ar_lite_vld(vld[0]), .user_aw_lite_vld(vld[1]), .user_w_lite_vld(vld[2]),
    .txfifo_ar_lite_data(din[0][31:0]), .txfifo_aw_lite_data(din[1][31:0]),
    .txfifo_w_lite_data(din[2]),
    .user_ar_lite_ready(user_ar_lite_ready), .user_aw_lite_ready(user_aw_lite_ready),
    .user_w_lite_ready(user_w_lite_ready),
    .tx_ar_push(tx_ar_push), .tx_aw_push(tx_aw_push), .tx_w_push(tx_w_push),
    .tx_ar_data(tx_ar_data), .tx_aw_data(tx_aw_data), .tx_w_data(tx_w_data),
    .rx_ar_credit(rx[0]), .rx_aw_credit(rx[1]), .rx_w_credit(rx[2]),
    .credit_err(credit_err)
  );

  // Reference model: per channel a circular queue, a credit count and the expected link outputs.
  logic [35:0] mbuf [3][16];
  int          hd [3];
  int          cnt [3];
  int          cred [3];
  logic        mpush [3];
  logic [35:0] mdata [3];
  logic        merr [3];
  bit          started;
  int          pushes [3];
  int          cyc;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      hd[c] = 0; cnt[c] = 0; cred[c] = INIT;
      mpush[c] = 1'b0; mdata[c] = '0; merr[c] = 1'b0; pushes[c] = 0;
    end
    started = 1'b0;
  endtask

  task automatic idle_inputs();
    vld = '0; rx = '0;
    for (int c = 0; c < 3; c++) din[c] = '0;
  endtask

  // Compare the visible outputs, advance the model with the applied inputs, move to the next negedge.
  task automatic cycle();
    bit rdy, w, p;
    logic [35:0] v;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("ready%0d", c), 64'(rdy_o[c]), 64'(started && (cnt[c] < D)));
      chk($sformatf("push%0d", c), 64'(push_o[c]), 64'(mpush[c]));
      chk($sformatf("data%0d", c), 64'(dat_o[c]), 64'(mdata[c]));
    end
    chk("credit_err", 64'(credit_err), 64'({merr[2], merr[1], merr[0]}));
    if (rst_n) begin
      for (int c = 0; c < 3; c++) begin
        rdy = started && (cnt[c] < D);
        w   = vld[c] && rdy;
        p   = (cnt[c] > 0) && (cred[c] > 0) && online;
        mpush[c] = p;
        if (p) begin
          mdata[c] = mbuf[c][hd[c]];
          hd[c] = (hd[c] + 1) % D;
          cnt[c]--;
        end
        if (w) begin
          v = (c == 2) ? din[c] : {4'b0, din[c][31:0]};
          mbuf[c][(hd[c] + cnt[c]) % D] = v;
          cnt[c]++;
        end
        if (p && !rx[c]) cred[c]--;
        else if (rx[c] && !p) begin
          if (cred[c] == INIT) begin
`ifdef AXI_LITE_LL_TX_CREDIT_ERR_EN
            merr[c] = 1'b1;
`endif
          end else cred[c]++;
        end
      end
      started = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    for (int c = 0; c < 3; c++) if (push_o[c]) pushes[c]++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    online = 1'b0;
    #1;
    model_reset();
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic write_n(input int c, input int n, input logic [35:0] base);
    for (int i = 0; i < n; i++) begin
      vld[c] = 1'b1;
      din[c] = base + 36'(i);
      cycle();
    end
    vld[c] = 1'b0;
  endtask

  int acc, k, last;

  initial begin
    cyc = 0;
    rst_n = 1'b0;
    online = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    #1;
    cycle();
    chk("reset_ready", 64'(rdy_o), 64'(3'b000));
    chk("reset_push", 64'(push_o), 64'(3'b000));
    chk("reset_wdata", 64'(tx_w_data), 64'h0);
    rst_n = 1'b1;
    cycle();
    chk("ready_after_release", 64'(rdy_o), 64'(3'b111));

    // Single AR transfer latency and credit consumption.
    online = 1'b1;
    vld[0] = 1'b1; din[0] = 36'h0_1000_0040;
    cycle();
    vld[0] = 1'b0;
    chk("ar_push_n1", 64'(tx_ar_push), 64'h0);
    cycle();
    chk("ar_push_n2", 64'(tx_ar_push), 64'h1);
    chk("ar_data", 64'(tx_ar_data), 64'h1000_0040);
    chk("ar_credit_model", 64'(cred[0]), 64'd7);
    cycle();
    chk("ar_data_hold", 64'(tx_ar_data), 64'h1000_0040);

    // Ten W writes against eight credits.
    do_reset();
    online = 1'b1;
    for (int i = 0; i < 10; i++) begin
      vld[2] = 1'b1; din[2] = {$urandom_range(15, 0), $urandom};
      chk("w_ready_high", 64'(user_w_lite_ready), 64'h1);
      cycle();
    end
    vld[2] = 1'b0;
    repeat (6) cycle();
    chk("w_push_count8", 64'(pushes[2]), 64'd8);
    chk("w_held2", 64'(cnt[2]), 64'd2);
    rx[2] = 1'b1;
    cycle();
    rx[2] = 1'b0;
    repeat (3) cycle();
    chk("w_push_count9", 64'(pushes[2]), 64'd9);

    // AW offline fill, then drain in order.
    do_reset();
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      vld[1] = 1'b1; din[1] = 36'hA0 + 36'(i);
      if (user_aw_lite_ready) acc++;
      if (i == 4) chk("aw_ready_low_fifth", 64'(user_aw_lite_ready), 64'h0);
      cycle();
    end
    vld[1] = 1'b0;
    chk("aw_accepted4", 64'(acc), 64'd4);
    online = 1'b1;
    k = 0; last = 0;
    for (int j = 0; j < 8; j++) begin
      cycle();
      if (tx_aw_push) begin
        chk("aw_order", 64'(tx_aw_data), 64'h0A0 + 64'(k));
        if (k > 0) chk("aw_consecutive", 64'(cyc), 64'(last + 1));
        last = cyc;
        k++;
      end
    end
    chk("aw_push_count4", 64'(k), 64'd4);

    // Credit return with the counter already full.
    do_reset();
    rx[0] = 1'b1;
    cycle();
    rx[0] = 1'b0;
    cycle();
    chk("ar_credit_sat_model", 64'(cred[0]), 64'd8);
`ifdef AXI_LITE_LL_TX_CREDIT_ERR_EN
    chk("ar_credit_err", 64'(credit_err[0]), 64'h1);
`else
    chk("ar_credit_err", 64'(credit_err[0]), 64'h0);
`endif
    online = 1'b1;
    write_n(0, 10, 36'h300);
    repeat (6) cycle();
    chk("ar_sat_push_count8", 64'(pushes[0]), 64'd8);

    // Simultaneous pop and credit return at credit 3.
    do_reset();
    online = 1'b1;
    write_n(1, 5, 36'h500);
    repeat (4) cycle();
    chk("aw_credit3_model", 64'(cred[1]), 64'd3);
    chk("aw_push5", 64'(pushes[1]), 64'd5);
    vld[1] = 1'b1; din[1] = 36'h5AA;
    cycle();
    vld[1] = 1'b0;
    rx[1] = 1'b1;
    cycle();
    rx[1] = 1'b0;
    chk("aw_pop_with_credit", 64'(tx_aw_push), 64'h1);
    chk("aw_credit_still3", 64'(cred[1]), 64'd3);
    write_n(1, 6, 36'h600);
    repeat (6) cycle();
    chk("aw_push9", 64'(pushes[1]), 64'd9);

    // Reset with queued W entries discards them.
    do_reset();
    write_n(2, 3, 36'h9_0000_0001);
    chk("w_queued3", 64'(cnt[2]), 64'd3);
    rst_n = 1'b0;
    #1;
    model_reset();
    cycle();
    cycle();
    rst_n = 1'b1;
    online = 1'b1;
    cycle();
    chk("w_ready_post_reset", 64'(user_w_lite_ready), 64'h1);
    repeat (5) cycle();
    chk("w_no_stale_push", 64'(pushes[2]), 64'd0);
    write_n(2, 10, 36'h7_0000_0000);
    repeat (6) cycle();
    chk("w_fresh_credit8", 64'(pushes[2]), 64'd8);

    // Randomized traffic on all channels.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      for (int c = 0; c < 3; c++) begin
        vld[c] = ($urandom_range(99, 0) < 60);
        din[c] = {4'($urandom), $urandom};
        rx[c]  = ($urandom_range(99, 0) < 30);
      end
      online = ($urandom_range(99, 0) < 80);
      cycle();
    end
    idle_inputs();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_lite_a32_d32_master_ll_tx.md
AXI_LITE_A32_D32_MASTER_LL_TX -- requirements
Module: axi_lite_a32_d32_master_ll_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: entries per channel transmit FIFO; power of two, 2..16.
REQ-002 Parameter INIT_CREDIT, default 8: far-end receive-buffer credits per channel after reset; 1..15.
REQ-003 Port clk_wr  input  1  single clock for all logic.
REQ-004 Port rst_wr_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port tx_online  input  1  link up; transmission is permitted only while high.
REQ-006 Ports user_ar_lite_vld / user_aw_lite_vld / user_w_lite_vld  input  1 each  upstream valid per channel.
REQ-007 Ports txfifo_ar_lite_data / txfifo_aw_lite_data  input  32 each; txfifo_w_lite_data  input  36  upstream payload.
REQ-008 Ports user_ar_lite_ready / user_aw_lite_ready / user_w_lite_ready  output  1 each  FIFO accepting.
REQ-009 Ports tx_ar_push / tx_aw_push / tx_w_push  output  1 each  one-cycle pulse, payload presented to link.
REQ-010 Ports tx_ar_data / tx_aw_data  output  32 each; tx_w_data  output  36  link payload, valid with push.
REQ-011 Ports rx_ar_credit / rx_aw_credit / rx_w_credit  input  1 each  pulse, far end freed one entry.
REQ-012 Port credit_err  output  3  sticky credit-overflow flag, bit0 ar, bit1 aw, bit2 w.

Function
REQ-013 The three channels SHALL be independent instances of identical logic; no arbitration between them.
REQ-014 user_X_lite_ready SHALL equal "FIFO occupancy < FIFO_DEPTH", derived from registered state only.
REQ-015 Write into FIFO SHALL occur on a cycle with user_X_lite_vld and user_X_lite_ready both high.
REQ-016 Pop condition: FIFO non-empty AND credit > 0 AND tx_online high.
REQ-017 On pop, tx_X_push SHALL be high the next cycle with tx_X_data = head entry; push and data are registered.
REQ-018 Latency: write at cycle N into an empty FIFO with credit available -> tx_X_push at N+2.
REQ-019 Sustained throughput SHALL be one push per cycle while pop condition holds.
REQ-020 Simultaneous write and pop on a full FIFO SHALL NOT be accepted (ready low); on a non-full, non-empty FIFO both SHALL occur, occupancy unchanged.
REQ-021 Write and read pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width = log2(FIFO_DEPTH)+1.
REQ-022 Credit counter (4 bits): pop decrements, rx_X_credit increments; both same cycle -> unchanged.
REQ-023 rx_X_credit with credit already at INIT_CREDIT (no pop that cycle) SHALL saturate at INIT_CREDIT.
REQ-024 tx_X_data SHALL hold its last value when tx_X_push is low.
REQ-025 tx_online falling SHALL block further pops from the next cycle; a push already registered still issues; FIFO contents and credits retained.

Reset
REQ-026 While rst_wr_n low: FIFOs empty, pointers 0, credit = INIT_CREDIT, tx_X_push 0, tx_X_data 0, credit_err 0.
REQ-027 user_X_lite_ready SHALL be 0 during reset and 1 from the first clock edge after deassertion.
REQ-028 Reset mid-transfer SHALL discard all queued entries; no push SHALL issue for pre-reset data.

Configuration
REQ-029 Macro AXI_LITE_LL_TX_CREDIT_ERR_EN defined: credit_err bit sets on a saturating rx_X_credit (REQ-023) and stays set until reset.
REQ-030 Macro undefined: credit_err tied to 0; saturation behaviour of REQ-023 unchanged.

Verification
REQ-031 Single AR write addr 0x1000_0040, tx_online=1 -> tx_ar_push at N+2, tx_ar_data=0x1000_0040, credit 8->7.
REQ-032 Ten back-to-back W writes, no rx_w_credit -> exactly 8 pushes, 2 entries held, ready stays high; one rx_w_credit -> 9th push.
REQ-033 tx_online=0, five AW writes -> four accepted, ready low on fifth; raise tx_online -> four pushes in order on consecutive cycles.
REQ-034 rx_ar_credit with credit=8 and no pop -> credit stays 8; credit_err[0]=1 with AXI_LITE_LL_TX_CREDIT_ERR_EN, 0 without.
REQ-035 Same-cycle pop and rx_aw_credit at credit=3 -> credit remains 3.
REQ-036 Assert rst_wr_n low with 3 queued W entries -> no push after release, credit=8, ready high one cycle after release.
